// File: rtl/alu_pkg.sv
// Shared types for the ALU op tracker: op encoding, FSM states, error ceiling.
// Pure declarations; no latency and no flow control.
// Nothing here holds state or can stall.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_MULT = 2'd0,
        OP_OR   = 2'd1,
        OP_AND  = 2'd2,
        OP_LAND = 2'd3
    } op_e;

    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    localparam logic [15:0] ERR_MAX = 16'hFFFF;

    // Number of set bits in a 4-bit op match vector.
    function automatic logic [2:0] count_ones4(input logic [3:0] v);
        count_ones4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

endpackage

// File: rtl/alu_ref_compute.sv
// Reference results for all four candidate ops from one operand pair.
// Purely combinational, zero latency.
// No flow control; outputs follow inputs continuously.
module alu_ref_compute (
    input  logic [7:0] in1,
    input  logic [7:0] in2,
    output logic [7:0] res_mult,
    output logic [7:0] res_or,
    output logic [7:0] res_and,
    output logic [7:0] res_land
);
    logic [15:0] product;

    assign product  = in1 * in2;
    assign res_mult = product[7:0];
    assign res_or   = in1 | in2;
    assign res_and  = in1 & in2;
    assign res_land = {7'd0, (in1 != 8'd0) && (in2 != 8'd0)};

endmodule

// File: rtl/alu_op_tracker.sv
// Identifies which op an observed ALU performs and tracks a rotating op sequence.
// Outputs registered: one clk after the accepted sample. No backpressure; every
// valid sample is consumed, idle cycles only clear the mismatch pulse.
module alu_op_tracker
    import alu_pkg::*;
#(
    parameter int MISS_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [7:0]  in1,
    input  logic [7:0]  in2,
    input  logic [7:0]  result,
    output logic        locked,
    output logic [1:0]  op_idx,
    output logic        mismatch,
    output logic [15:0] err_count
);
    localparam logic [3:0] LIMIT = MISS_LIMIT[3:0];

    logic [7:0] res_mult, res_or, res_and, res_land;
    logic [3:0] match_vec;
    logic [1:0] hit_idx;

    state_e      state_q, state_d;
    op_e         exp_q, exp_d;
    op_e         op_idx_q, op_idx_d;
    logic [3:0]  miss_q, miss_d;
    logic        mismatch_q, mismatch_d;
    logic [15:0] err_q, err_d;

    alu_ref_compute u_ref (
        .in1      (in1),
        .in2      (in2),
        .res_mult (res_mult),
        .res_or   (res_or),
        .res_and  (res_and),
        .res_land (res_land)
    );

    always_comb begin
        match_vec[OP_MULT] = (res_mult == result);
        match_vec[OP_OR]   = (res_or   == result);
        match_vec[OP_AND]  = (res_and  == result);
        match_vec[OP_LAND] = (res_land == result);
    end

    // Only meaningful when exactly one bit of match_vec is set.
    always_comb begin
        hit_idx = 2'd0;
        for (int k = 0; k < 4; k++) begin
            if (match_vec[k]) hit_idx = 2'(k);
        end
    end

    always_comb begin
        state_d    = state_q;
        exp_d      = exp_q;
        op_idx_d   = op_idx_q;
        miss_d     = miss_q;
        mismatch_d = 1'b0;
        err_d      = err_q;
        if (in_valid) begin
            unique case (state_q)
                ST_HUNT: begin
                    if (count_ones4(match_vec) == 3'd1) begin
                        state_d  = ST_LOCKED;
                        op_idx_d = op_e'(hit_idx);
                        exp_d    = op_e'(hit_idx + 2'd1);
                        miss_d   = 4'd0;
                    end
                end
                ST_LOCKED: begin
                    exp_d = op_e'(exp_q + 2'd1);
                    if (match_vec[exp_q]) begin
                        op_idx_d = exp_q;
                        miss_d   = 4'd0;
                    end else begin
                        mismatch_d = 1'b1;
                        err_d      = (err_q == ERR_MAX) ? err_q : err_q + 16'd1;
                        if (miss_q + 4'd1 == LIMIT) begin
                            state_d = ST_HUNT;
                            miss_d  = 4'd0;
                        end else begin
                            miss_d = miss_q + 4'd1;
                        end
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_HUNT;
            exp_q      <= OP_MULT;
            op_idx_q   <= OP_MULT;
            miss_q     <= 4'd0;
            mismatch_q <= 1'b0;
            err_q      <= 16'd0;
        end else begin
            state_q    <= state_d;
            exp_q      <= exp_d;
            op_idx_q   <= op_idx_d;
            miss_q     <= miss_d;
            mismatch_q <= mismatch_d;
            err_q      <= err_d;
        end
    end

    assign locked    = (state_q == ST_LOCKED);
    assign op_idx    = op_idx_q;
    assign mismatch  = mismatch_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_alu_op_tracker.sv
// Directed and randomized checks of alu_op_tracker against a behavioural model.
module tb_alu_op_tracker;
    localparam int LIMIT = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in1 = '0, in2 = '0, result = '0;
    logic        locked, mismatch;
    logic [1:0]  op_idx;
    logic [15:0] err_count;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Behavioural model state
    bit m_locked;
    int m_exp, m_miss, m_op, m_err;
    bit m_mm;

    alu_op_tracker #(.MISS_LIMIT(LIMIT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in1       (in1),
        .in2       (in2),
        .result    (result),
        .locked    (locked),
        .op_idx    (op_idx),
        .mismatch  (mismatch),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    function automatic int ref_of(input int op, input int a, input int b);
        case (op)
            0: return (a * b) % 256;
            1: return a | b;
            2: return a & b;
            default: return (a != 0 && b != 0) ? 1 : 0;
        endcase
    endfunction

    task automatic model_reset();
        m_locked = 0; m_exp = 0; m_miss = 0; m_op = 0; m_err = 0; m_mm = 0;
    endtask

    task automatic model_sample(input bit v, input int a, input int b, input int r);
        int hits, k_hit;
        m_mm = 0;
        if (!v) return;
        if (!m_locked) begin
            hits = 0; k_hit = 0;
            for (int k = 0; k < 4; k++)
                if (ref_of(k, a, b) == r) begin hits++; k_hit = k; end
            if (hits == 1) begin
                m_locked = 1; m_op = k_hit; m_exp = (k_hit + 1) % 4; m_miss = 0;
            end
        end else begin
            if (ref_of(m_exp, a, b) == r) begin
                m_op = m_exp; m_miss = 0;
            end else begin
                m_mm = 1;
                if (m_err < 65535) m_err++;
                m_miss++;
                if (m_miss == LIMIT) begin m_locked = 0; m_miss = 0; end
            end
            m_exp = (m_exp + 1) % 4;
        end
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        check({tag, ".locked"},   16'(locked),   16'(m_locked));
        check({tag, ".op_idx"},   16'(op_idx),   16'(m_op));
        check({tag, ".mismatch"}, 16'(mismatch), 16'(m_mm));
        check({tag, ".err"},      err_count,     16'(m_err));
    endtask

    // Drive at negedge, let one rising edge pass, compare 1 time unit later.
    task automatic step(input bit v, input int a, input int b, input int r, input string tag);
        @(negedge clk);
        in_valid = v; in1 = 8'(a); in2 = 8'(b); result = 8'(r);
        model_sample(v, a, b, r);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int a, b, r, op;
        bit v;
        model_reset();
        #1;
        check_all("reset_async");
        do_reset();
        @(posedge clk); #1;
        check_all("reset_state");

        // Lock on MULT, then walk the rotation OR, AND, LAND, MULT
        step(1, 6, 5, 30, "lock_mult");
        check("lock_mult.explicit", 16'({locked, op_idx}), 16'h4);
        step(1, 6, 5, 7,  "seq_or");
        step(1, 6, 5, 4,  "seq_and");
        step(1, 6, 5, 1,  "seq_land");
        step(1, 6, 5, 30, "seq_mult");

        // Idle gap must not advance the expected op (next expected is OR)
        for (int i = 0; i < 5; i++) step(0, 6, 5, 99, "gap");
        step(1, 6, 5, 7, "gap_then_or");
        check("gap_then_or.op", 16'(op_idx), 16'd1);

        // Ambiguous HUNT sample: all four ops give zero
        do_reset();
        step(1, 0, 0, 0, "hunt_ambiguous");
        check("hunt_ambiguous.locked", 16'(locked), 16'd0);

        // Miss counter cleared by a correct sample, then three misses unlock
        step(1, 6, 5, 30, "relock");
        step(1, 6, 5, 8'hFF, "miss1");
        step(1, 6, 5, 4, "recover_and");
        step(1, 6, 5, 8'hFF, "miss_a");
        step(1, 6, 5, 8'hFF, "miss_b");
        check("two_misses_still_locked", 16'(locked), 16'd1);
        step(1, 6, 5, 7, "recover_or");
        step(1, 6, 5, 8'hFF, "limit1");
        step(1, 6, 5, 8'hFF, "limit2");
        step(1, 6, 5, 8'hFF, "limit3");
        check("limit3.unlocked", 16'(locked), 16'd0);
        check("limit3.err", err_count, 16'd6);
        step(0, 0, 0, 0, "pulse_clears");

        // Asynchronous reset while locked with two errors
        do_reset();
        step(1, 6, 5, 30, "pre_rst_lock");
        step(1, 6, 5, 8'hFF, "pre_rst_m1");
        step(1, 6, 5, 8'hFF, "pre_rst_m2");
        check("pre_rst.err", err_count, 16'd2);
        @(negedge clk);
        in_valid = 1'b1; in1 = 8'd6; in2 = 8'd5; result = 8'd1;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_rst.locked", 16'(locked), 16'd0);
        check("async_rst.err", err_count, 16'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 3, 3, 9, "post_rst_hunt");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            v  = ($urandom_range(0, 9) < 8);
            a  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255);
            b  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255);
            op = $urandom_range(0, 3);
            r  = ($urandom_range(0, 9) < 7) ? ref_of(op, a, b) : $urandom_range(0, 255);
            step(v, a, b, r, "rand");
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
